axi_slv_wr_mem: RTL and testbench

AXI4 write-channel slave with an internal word-addressed memory. It is the downstream consumer of the master-side AW/W/B signals of the bus interface. It accepts one burst at a time, applies byte strobes, and returns a B response. Verification benches use it as the write target behind the VIP master driver, and memory contents are observable through a debug read port.

---
 rtl/axi_slv_wr_mem.sv | 160 ++++++++++++++++
 tb/tb_axi_slv_wr_mem.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slv_wr_mem.sv
// AXI4 write-channel slave backed by a word-addressed memory.
// Accepts one burst at a time, applies byte strobes, answers on B.
// Optional feature: define AXI_SLV_WID_CHECK_EN to reject W beats whose
// WID differs from the captured AWID (beat dropped, burst ends in SLVERR).
module axi_slv_wr_mem #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                         ACLK,
  input  logic                         ARSETn,
  input  logic [ID_WIDTH-1:0]          AWID,
  input  logic [ADDR_WIDTH-1:0]        AWADDR,
  input  logic [7:0]                   AWLEN,
  input  logic [2:0]                   AWSIZE,
  input  logic [1:0]                   AWBURST,
  input  logic [2:0]                   AWPROT,
  input  logic                         AWVALID,
  output logic                         AWREADY,
  input  logic [ID_WIDTH-1:0]          WID,
  input  logic [DATA_WIDTH-1:0]        WDATA,
  input  logic [DATA_WIDTH/8-1:0]      WSTRB,
  input  logic                         WLAST,
  input  logic                         WVALID,
  output logic                         WREADY,
  output logic [ID_WIDTH-1:0]          BID,
  output logic [1:0]                   BRESP,
  output logic                         BVALID,
  input  logic                         BREADY,
  input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0]        dbg_rdata
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int LANE_BITS  = $clog2(STRB_WIDTH);
  localparam int IDX_WIDTH  = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

  state_t                  state, next_state;
  logic                    awready_q, wready_q, bvalid_q;
  logic [1:0]              bresp_q;
  logic [ID_WIDTH-1:0]     id_q;
  logic [ADDR_WIDTH-1:0]   addr_q, next_addr, incr, wrap_mask, word_addr;
  logic [7:0]              len_q, beat_cnt;
  logic [2:0]              size_q;
  logic [1:0]              burst_q;
  logic                    err_q, bad_q;
  logic                    aw_hs, w_hs, b_hs, last_beat, aw_bad;
  logic                    in_range, wid_ok, beat_err, beat_we;
  logic [IDX_WIDTH-1:0]    word_idx;
  logic                    unused_in;
  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

  assign AWREADY   = awready_q;
  assign WREADY    = wready_q;
  assign BVALID    = bvalid_q;
  assign BRESP     = bresp_q;
  assign BID       = id_q;
  assign dbg_rdata = mem[dbg_addr];

  assign aw_hs     = AWVALID && awready_q;
  assign w_hs      = WVALID && wready_q;
  assign b_hs      = bvalid_q && BREADY;
  assign last_beat = (beat_cnt == len_q) || WLAST;

  // A burst that can never be written legally is flagged once at AW time
  assign aw_bad = (AWSIZE > 3'(LANE_BITS)) || (AWBURST == 2'b11) ||
                  ((AWBURST == 2'b10) && !(AWLEN inside {8'd1, 8'd3, 8'd7, 8'd15}));

  assign word_addr = addr_q >> LANE_BITS;
  assign word_idx  = word_addr[IDX_WIDTH-1:0];
  assign in_range  = word_addr < ADDR_WIDTH'(MEM_DEPTH);

`ifdef AXI_SLV_WID_CHECK_EN
  assign wid_ok    = (WID == id_q);
  assign unused_in = ^AWPROT;
`else
  assign wid_ok    = 1'b1;
  assign unused_in = ^{AWPROT, WID};
`endif

  // WLAST disagreeing with the beat count covers both early and missing WLAST
  assign beat_err = !in_range || !wid_ok || (WLAST != (beat_cnt == len_q));
  assign beat_we  = w_hs && !bad_q && in_range && wid_ok;

  // Address for the following beat according to the captured burst type
  always_comb begin
    incr      = ADDR_WIDTH'(1) << size_q;
    wrap_mask = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);
    next_addr = addr_q;
    case (burst_q)
      2'b01:   next_addr = addr_q + incr;
      2'b10:   next_addr = (addr_q & ~wrap_mask) | ((addr_q + incr) & wrap_mask);
      default: next_addr = addr_q;
    endcase
  end

  // Next-state logic: one burst travels IDLE -> DATA -> RESP -> IDLE
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (aw_hs) next_state = DATA;
      DATA:    if (w_hs && last_beat) next_state = RESP;
      RESP:    if (b_hs) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State, registered handshake outputs and captured burst context
  always_ff @(posedge ACLK or negedge ARSETn) begin
    if (!ARSETn) begin
      state     <= IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      beat_cnt  <= '0;
      err_q     <= 1'b0;
      bad_q     <= 1'b0;
    end else begin
      state     <= next_state;
      awready_q <= (next_state == IDLE);
      wready_q  <= (next_state == DATA);
      bvalid_q  <= (next_state == RESP);
      if (aw_hs) begin
        id_q     <= AWID;
        addr_q   <= AWADDR;
        len_q    <= AWLEN;
        size_q   <= AWSIZE;
        burst_q  <= AWBURST;
        beat_cnt <= '0;
        err_q    <= aw_bad;
        bad_q    <= aw_bad;
      end
      if (w_hs) begin
        addr_q   <= next_addr;
        beat_cnt <= beat_cnt + 8'd1;
        err_q    <= err_q || beat_err;
        if (last_beat) bresp_q <= (err_q || beat_err) ? 2'b10 : 2'b00;
      end
    end
  end

  // Byte-lane writes into the unreset storage array
  always_ff @(posedge ACLK) begin
    if (beat_we) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (WSTRB[b]) mem[word_idx][b*8 +: 8] <= WDATA[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_slv_wr_mem.sv
// Directed bench for axi_slv_wr_mem with a B-response scoreboard.
// Honours AXI_SLV_WID_CHECK_EN by adding a WID-mismatch burst.
module tb_axi_slv_wr_mem;

  localparam int ID_WIDTH   = 4;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int MEM_DEPTH  = 256;

  logic                  ACLK, ARSETn;
  logic [ID_WIDTH-1:0]   AWID, WID, BID;
  logic [ADDR_WIDTH-1:0] AWADDR;
  logic [7:0]            AWLEN;
  logic [2:0]            AWSIZE, AWPROT;
  logic [1:0]            AWBURST, BRESP;
  logic                  AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic [DATA_WIDTH-1:0] WDATA, dbg_rdata;
  logic [3:0]            WSTRB;
  logic [7:0]            dbg_addr;

  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    logic [1:0]          resp;
  } b_exp_t;

  b_exp_t sb_q[$];
  int     checks = 0;
  int     fails  = 0;

  axi_slv_wr_mem #(
    .ID_WIDTH(ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH), .MEM_DEPTH(MEM_DEPTH)
  ) dut (
    .ACLK(ACLK), .ARSETn(ARSETn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
    .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata)
  );

  // Free-running clock
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Guard against a stuck run
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_mem(input string tag, input logic [7:0] idx, input logic [31:0] exp);
    dbg_addr = idx;
    #1;
    check(tag, dbg_rdata, exp);
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    @(negedge ACLK);
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst;
    AWVALID = 1'b1;
    WID = id;
    while (!AWREADY && n < 50) begin @(negedge ACLK); n++; end
    check("aw_ready", AWREADY, 1'b1);
    @(negedge ACLK);
    AWVALID = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n = 0;
    @(negedge ACLK);
    WDATA = data; WSTRB = strb; WLAST = last; WVALID = 1'b1;
    while (!WREADY && n < 50) begin @(negedge ACLK); n++; end
    check("w_ready", WREADY, 1'b1);
    @(negedge ACLK);
    WVALID = 1'b0; WLAST = 1'b0;
  endtask

  task automatic get_b(input int hold);
    int     n = 0;
    b_exp_t exp;
    while (!BVALID && n < 50) begin @(negedge ACLK); n++; end
    check("b_valid", BVALID, 1'b1);
    check("sb_has_entry", (sb_q.size() > 0), 1'b1);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    check("b_id", BID, exp.id);
    check("b_resp", BRESP, exp.resp);
    for (int i = 0; i < hold; i++) begin
      @(negedge ACLK);
      check("b_hold_valid", BVALID, 1'b1);
      check("b_hold_id", BID, exp.id);
      check("b_hold_resp", BRESP, exp.resp);
      check("aw_ready_in_resp", AWREADY, 1'b0);
    end
    BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;
    check("b_valid_after_b", BVALID, 1'b0);
    check("aw_ready_after_b", AWREADY, 1'b1);
  endtask

  // Directed sequence
  initial begin
    ARSETn = 1'b0; AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0;
    AWPROT = '0; AWVALID = 1'b0; WID = '0; WDATA = '0; WSTRB = '0; WLAST = 1'b0;
    WVALID = 1'b0; BREADY = 1'b0; dbg_addr = '0;

    repeat (3) @(negedge ACLK);
    $display("[TB] reset values");
    check("rst_awready", AWREADY, 1'b0);
    check("rst_wready", WREADY, 1'b0);
    check("rst_bvalid", BVALID, 1'b0);
    check("rst_bresp", BRESP, 2'b00);
    check("rst_bid", BID, 4'h0);
    ARSETn = 1'b1;
    @(negedge ACLK);
    check("awready_after_rst", AWREADY, 1'b1);

    $display("[TB] INCR burst");
    send_aw(4'h5, 32'h10, 8'd3, 3'd2, 2'b01);
    sb_q.push_back('{id: 4'h5, resp: 2'b00});
    send_w(32'hA0, 4'hF, 1'b0);
    check("incr_aw_closed", AWREADY, 1'b0);
    send_w(32'hA1, 4'hF, 1'b0);
    send_w(32'hA2, 4'hF, 1'b0);
    check("incr_no_early_b", BVALID, 1'b0);
    send_w(32'hA3, 4'hF, 1'b1);
    check("incr_b_latency", BVALID, 1'b1);
    check("incr_wready_low", WREADY, 1'b0);
    get_b(0);
    check_mem("incr_m4", 8'h04, 32'hA0);
    check_mem("incr_m5", 8'h05, 32'hA1);
    check_mem("incr_m6", 8'h06, 32'hA2);
    check_mem("incr_m7", 8'h07, 32'hA3);

    $display("[TB] WRAP burst");
    send_aw(4'h2, 32'h38, 8'd3, 3'd2, 2'b10);
    sb_q.push_back('{id: 4'h2, resp: 2'b00});
    send_w(32'd1, 4'hF, 1'b0);
    send_w(32'd2, 4'hF, 1'b0);
    send_w(32'd3, 4'hF, 1'b0);
    send_w(32'd4, 4'hF, 1'b1);
    get_b(0);
    check_mem("wrap_mE", 8'h0E, 32'd1);
    check_mem("wrap_mF", 8'h0F, 32'd2);
    check_mem("wrap_mC", 8'h0C, 32'd3);
    check_mem("wrap_mD", 8'h0D, 32'd4);

    $display("[TB] FIXED burst with strobes");
    send_aw(4'h1, 32'h0, 8'd0, 3'd2, 2'b01);
    sb_q.push_back('{id: 4'h1, resp: 2'b00});
    send_w(32'h0, 4'hF, 1'b1);
    get_b(0);
    send_aw(4'h1, 32'h0, 8'd1, 3'd2, 2'b00);
    sb_q.push_back('{id: 4'h1, resp: 2'b00});
    send_w(32'h11223344, 4'b0011, 1'b0);
    send_w(32'hAABBCCDD, 4'b1100, 1'b1);
    get_b(0);
    check_mem("fixed_m0", 8'h00, 32'hAABB3344);

    $display("[TB] early WLAST");
    send_aw(4'h3, 32'h80, 8'd3, 3'd2, 2'b01);
    sb_q.push_back('{id: 4'h3, resp: 2'b10});
    send_w(32'h55, 4'hF, 1'b0);
    send_w(32'h66, 4'hF, 1'b1);
    check("early_wready_low", WREADY, 1'b0);
    check("early_bvalid", BVALID, 1'b1);
    get_b(0);
    check_mem("early_m20", 8'h20, 32'h55);
    check_mem("early_m21", 8'h21, 32'h66);

    $display("[TB] missing WLAST on final beat");
    send_aw(4'h6, 32'h40, 8'd0, 3'd2, 2'b01);
    sb_q.push_back('{id: 4'h6, resp: 2'b10});
    send_w(32'h77, 4'hF, 1'b0);
    check("nolast_bvalid", BVALID, 1'b1);
    get_b(0);
    check_mem("nolast_m10", 8'h10, 32'h77);

    $display("[TB] out-of-range with backpressure");
    send_aw(4'h7, 32'(MEM_DEPTH * 4), 8'd0, 3'd2, 2'b01);
    sb_q.push_back('{id: 4'h7, resp: 2'b10});
    send_w(32'hDEADBEEF, 4'hF, 1'b1);
    get_b(5);
    check_mem("oor_m0_kept", 8'h00, 32'hAABB3344);

    $display("[TB] oversized AWSIZE");
    send_aw(4'h4, 32'h10, 8'd0, 3'd3, 2'b01);
    sb_q.push_back('{id: 4'h4, resp: 2'b10});
    send_w(32'hFFFFFFFF, 4'hF, 1'b1);
    get_b(0);
    check_mem("size_m4_kept", 8'h04, 32'hA0);

    $display("[TB] WRAP with illegal length");
    send_aw(4'h8, 32'h14, 8'd2, 3'd2, 2'b10);
    sb_q.push_back('{id: 4'h8, resp: 2'b10});
    send_w(32'hE0, 4'hF, 1'b0);
    send_w(32'hE1, 4'hF, 1'b0);
    send_w(32'hE2, 4'hF, 1'b1);
    get_b(0);
    check_mem("wlen_m5_kept", 8'h05, 32'hA1);
    check_mem("wlen_m6_kept", 8'h06, 32'hA2);
    check_mem("wlen_m7_kept", 8'h07, 32'hA3);

`ifdef AXI_SLV_WID_CHECK_EN
    $display("[TB] WID mismatch");
    send_aw(4'hB, 32'h200, 8'd0, 3'd2, 2'b01);
    sb_q.push_back('{id: 4'hB, resp: 2'b00});
    send_w(32'h11111111, 4'hF, 1'b1);
    get_b(0);
    send_aw(4'hA, 32'h200, 8'd1, 3'd2, 2'b01);
    sb_q.push_back('{id: 4'hA, resp: 2'b10});
    WID = 4'h3;
    send_w(32'hBAD, 4'hF, 1'b0);
    WID = 4'hA;
    send_w(32'h600D, 4'hF, 1'b1);
    get_b(0);
    check_mem("wid_m80_kept", 8'h80, 32'h11111111);
    check_mem("wid_m81", 8'h81, 32'h600D);
`endif

    $display("[TB] reset mid-burst");
    send_aw(4'h9, 32'h100, 8'd3, 3'd2, 2'b01);
    send_w(32'h123, 4'hF, 1'b0);
    send_w(32'h456, 4'hF, 1'b0);
    ARSETn = 1'b0;
    #1;
    check("mid_rst_awready", AWREADY, 1'b0);
    check("mid_rst_wready", WREADY, 1'b0);
    check("mid_rst_bvalid", BVALID, 1'b0);
    check("mid_rst_bresp", BRESP, 2'b00);
    check("mid_rst_bid", BID, 4'h0);
    @(negedge ACLK);
    ARSETn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      check("mid_rst_no_b", BVALID, 1'b0);
    end
    check("mid_rst_awready_back", AWREADY, 1'b1);
    check_mem("mid_rst_m40", 8'h40, 32'h123);
    check_mem("mid_rst_m41", 8'h41, 32'h456);

    $display("[TB] recovery burst");
    send_aw(4'hF, 32'h20, 8'd1, 3'd2, 2'b01);
    sb_q.push_back('{id: 4'hF, resp: 2'b00});
    send_w(32'hC0, 4'hF, 1'b0);
    send_w(32'hC1, 4'hF, 1'b1);
    get_b(0);
    check_mem("rec_m8", 8'h08, 32'hC0);
    check_mem("rec_m9", 8'h09, 32'hC1);
    check("sb_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
